unidade_controle_seq: RTL and testbench

//   Multi-cycle sequencer for the processing unit (register file + ULA).

---
 rtl/unidade_controle_seq.sv | 117 +++++++++++
 tb/tb_unidade_controle_seq.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_seq.sv
// unidade_controle_seq
//   Multi-cycle sequencer for the processing unit (register file + ULA).
//   Takes one instruction word per valid/ready handshake. It then walks
//   READ -> EXEC -> WRITE while holding controle and the three register
//   addresses steady. Ops whose code is >= LONG_OP_MIN produce 64-bit hi/lo
//   results and get a longer EXEC phase.
//
//   state | meaning
//   IDLE  | ready for a new instruction, outputs hold the last decoded value
//   READ  | register file reads src1/src2 (1 cycle)
//   EXEC  | ULA works; counter runs down to 0
//   WRITE | writeRegs (unless dest==0) and done pulse, count retires (1 cycle)
//
// Ports
//   clock, reset          rising-edge clock, async active-high reset
//   instr_valid/ready     handshake; ready only in IDLE
//   instr[31:0]           [31:28] op, [27:22] dest, [21:16] src1, [15:10] src2
//   abort                 drops the in-flight instruction from READ or EXEC
//   controle              ULA operation select
//   writeRegs             register-file write enable
//   endereco_escrita      write address
//   endereco_leitura1/2   read addresses
//   busy                  not in IDLE
//   done                  one-cycle pulse in WRITE
//   instr_count           retired instructions, wraps at 16 bits
module unidade_controle_seq #(
  parameter int unsigned EXEC_CYCLES      = 1,
  parameter int unsigned LONG_EXEC_CYCLES = 4,
  parameter logic [3:0]  LONG_OP_MIN      = 4'hC,
  // Value loaded into instr_count by reset; 0 in normal use.
  parameter logic [15:0] INSTR_COUNT_INIT = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic        abort,
  output logic [3:0]  controle,
  output logic        writeRegs,
  output logic [5:0]  endereco_escrita,
  output logic [5:0]  endereco_leitura1,
  output logic [5:0]  endereco_leitura2,
  output logic        busy,
  output logic        done,
  output logic [15:0] instr_count
);

  localparam int unsigned MAX_CYCLES =
    (EXEC_CYCLES > LONG_EXEC_CYCLES) ? EXEC_CYCLES : LONG_EXEC_CYCLES;
  localparam int CNT_W = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_SHORT = CNT_W'(EXEC_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_LONG  = CNT_W'(LONG_EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] exec_cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (instr_valid) state_nxt = READ;
      READ:  state_nxt = abort ? IDLE : EXEC;
      EXEC: begin
        if (abort)              state_nxt = IDLE;
        else if (exec_cnt == '0) state_nxt = WRITE;
      end
      WRITE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      exec_cnt          <= '0;
      controle          <= '0;
      endereco_escrita  <= '0;
      endereco_leitura1 <= '0;
      endereco_leitura2 <= '0;
      writeRegs         <= 1'b0;
      done              <= 1'b0;
      instr_count       <= INSTR_COUNT_INIT;
    end else begin
      state <= state_nxt;

      if (state == IDLE && instr_valid) begin
        controle          <= instr[31:28];
        endereco_escrita  <= instr[27:22];
        endereco_leitura1 <= instr[21:16];
        endereco_leitura2 <= instr[15:10];
      end

      // The op is already latched in controle by the time READ runs.
      if (state == READ)
        exec_cnt <= (controle >= LONG_OP_MIN) ? LOAD_LONG : LOAD_SHORT;
      else if (state == EXEC && exec_cnt != '0)
        exec_cnt <= exec_cnt - 1'b1;

      // Registered so both strobes are clean and line up exactly with WRITE.
      writeRegs <= (state_nxt == WRITE) && (endereco_escrita != 6'd0);
      done      <= (state_nxt == WRITE);
      if (state_nxt == WRITE)
        instr_count <= instr_count + 16'd1;
    end
  end

  assign busy        = (state != IDLE);
  assign instr_ready = (state == IDLE);

endmodule

// File: tb/tb_unidade_controle_seq.sv
module tb_unidade_controle_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        abort;

  logic        instr_ready, writeRegs, busy, done;
  logic [3:0]  controle;
  logic [5:0]  endereco_escrita, endereco_leitura1, endereco_leitura2;
  logic [15:0] instr_count;

  logic        w_ready, w_wr, w_busy, w_done;
  logic [3:0]  w_ctl;
  logic [5:0]  w_ew, w_el1, w_el2;
  logic [15:0] w_count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] exp_count;

  always #5 clock = ~clock;

  unidade_controle_seq dut (
    .clock(clock), .reset(reset), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr(instr), .abort(abort),
    .controle(controle), .writeRegs(writeRegs),
    .endereco_escrita(endereco_escrita), .endereco_leitura1(endereco_leitura1),
    .endereco_leitura2(endereco_leitura2), .busy(busy), .done(done),
    .instr_count(instr_count)
  );

  // Same stimulus, counter starting at 16'hFFFF: first retirement must wrap.
  unidade_controle_seq #(.INSTR_COUNT_INIT(16'hFFFF)) dut_wrap (
    .clock(clock), .reset(reset), .instr_valid(instr_valid),
    .instr_ready(w_ready), .instr(instr), .abort(abort),
    .controle(w_ctl), .writeRegs(w_wr),
    .endereco_escrita(w_ew), .endereco_leitura1(w_el1),
    .endereco_leitura2(w_el2), .busy(w_busy), .done(w_done),
    .instr_count(w_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input logic [3:0] op, input logic [5:0] d, s1, s2);
    chk("idle_busy", busy, 0);
    chk("idle_ready", instr_ready, 1);
    chk("idle_wr", writeRegs, 0);
    chk("idle_done", done, 0);
    chk("idle_count", instr_count, exp_count);
    chk("idle_wrap_count", w_count, 16'(exp_count + 16'hFFFF));
    chk("idle_hold_ctl", controle, op);
    chk("idle_hold_addr", {endereco_escrita, endereco_leitura1, endereco_leitura2}, {d, s1, s2});
  endtask

  // Offers one instruction and follows it to the end. After the accept edge,
  // index j counts further edges: READ is j=0, EXEC is j=1..n, WRITE is j=n+1.
  // abort_at in 0..n raises abort in that phase; abort in WRITE is thrown in
  // at random and must be ignored.
  task automatic run_instr(input logic [3:0] op, input logic [5:0] d, s1, s2,
                           input int abort_at, input bit abort_on_accept);
    int n;
    bit aborted;
    n = (op >= 4'hC) ? 4 : 1;
    aborted = 0;
    chk("pre_ready", instr_ready, 1);
    instr = {op, d, s1, s2, 10'($urandom)};
    instr_valid = 1;
    abort = abort_on_accept;
    @(posedge clock); #1;
    instr_valid = 0;
    abort = 0;
    for (int j = 0; j <= n + 1; j++) begin
      chk("busy", busy, 1);
      chk("ready", instr_ready, 0);
      chk("controle", controle, op);
      chk("addr_wr", endereco_escrita, d);
      chk("addr_rd1", endereco_leitura1, s1);
      chk("addr_rd2", endereco_leitura2, s2);
      chk("writeRegs", writeRegs, (j == n + 1) && (d != 6'd0));
      chk("done", done, j == n + 1);
      if (j <= n) chk("count_hold", instr_count, exp_count);
      instr_valid = 1'($urandom_range(0, 1));
      instr = $urandom;
      abort = (j == abort_at) || ((j == n + 1) && ($urandom_range(0, 1) == 1));
      @(posedge clock); #1;
      if (j == abort_at) begin
        aborted = 1;
        break;
      end
    end
    instr_valid = 0;
    abort = 0;
    if (!aborted) exp_count = exp_count + 16'd1;
    chk_idle(op, d, s1, s2);
  endtask

  initial begin
    reset = 1;
    instr_valid = 0;
    abort = 0;
    instr = '0;
    exp_count = 16'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ctl", controle, 0);
    chk("rst_addr", {endereco_escrita, endereco_leitura1, endereco_leitura2}, 0);
    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", instr_count, 0);
    reset = 0;

    // Reset in the middle of a long EXEC discards the instruction.
    instr = {4'hE, 6'd9, 6'd3, 6'd4, 10'd0};
    instr_valid = 1;
    @(posedge clock); #1;
    instr_valid = 0;
    repeat (2) @(posedge clock);
    #2;
    chk("mid_busy", busy, 1);
    reset = 1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_ready", instr_ready, 1);
    chk("async_ctl", controle, 0);
    chk("async_addr", {endereco_escrita, endereco_leitura1, endereco_leitura2}, 0);
    chk("async_count", instr_count, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("rst_no_wr", writeRegs, 0);
      chk("rst_no_done", done, 0);
    end
    reset = 0;
    @(posedge clock); #1;

    run_instr(4'h2, 6'd5, 6'd1, 6'd2, -1, 0);   // short op
    run_instr(4'hD, 6'd7, 6'd3, 6'd4, -1, 0);   // long op
    run_instr(4'h1, 6'd0, 6'd9, 6'd10, -1, 0);  // dest 0: done but no write
    run_instr(4'h3, 6'd6, 6'd1, 6'd1, 1, 0);    // abort in short EXEC
    run_instr(4'hC, 6'd8, 6'd2, 6'd2, 3, 0);    // abort in long EXEC
    run_instr(4'h5, 6'd11, 6'd4, 6'd5, 0, 0);   // abort in READ
    run_instr(4'h4, 6'd12, 6'd6, 6'd7, -1, 1);  // abort with valid in IDLE
    run_instr(4'hF, 6'd63, 6'd63, 6'd63, -1, 0);

    for (int k = 0; k < 60; k++) begin
      logic [3:0] op;
      logic [5:0] d, s1, s2;
      int a, n;
      op = 4'($urandom);
      d  = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom);
      s1 = 6'($urandom);
      s2 = 6'($urandom);
      n  = (op >= 4'hC) ? 4 : 1;
      a  = $urandom_range(0, 9);
      if (a > n) a = -1;
      run_instr(op, d, s1, s2, a, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clock); #1;
        chk("gap_idle", busy, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
